aes_128_feeder: RTL and testbench

- Upstream input stage for the pipelined aes_128 core.
- Accepts a 32-bit word stream and assembles 128-bit plaintext blocks, big-endian (first word = bits 127:96).
- Issues each complete block with its key to the core for exactly one cycle.
- Tracks blocks in flight through the core's fixed latency and flags the core's output as valid with a block count.

---
 rtl/aes_128_feeder.sv | 103 ++++++++++
 tb/tb_aes_128_feeder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_feeder.sv
// aes_128_feeder: front end for the pipelined aes_128 core.
// Packs a 32-bit word stream into 128-bit big-endian blocks and hands each
// block to the core with its key for one cycle. It also follows every block
// through the core's fixed latency, so it can mark the result on core_out as
// valid and count completed blocks.
module aes_128_feeder #(
    parameter int LATENCY = 21,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     key_in,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic [127:0]     aes_state,
    output logic [127:0]     aes_key,
    input  logic [127:0]     core_out,
    output logic [127:0]     dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);
    localparam int FL_W = $clog2(LATENCY + 1);

    logic [1:0]         word_cnt;
    logic [95:0]        asm_reg;   // words 0..2 of the block being assembled
    logic [127:0]       key_hold;  // key captured with word 0
    logic [LATENCY-1:0] vsr;       // vsr[0] is the issue flag; one bit per core stage
    logic [FL_W-1:0]    in_flight;
    logic               accept;
    logic               issue;

    // The core accepts one block per cycle, so only reset and abort can stall input.
    assign din_ready  = ~rst & ~abort;
    assign accept     = din_valid & din_ready;
    assign issue      = accept & (word_cnt == 2'd3);
    assign dout       = core_out;
    assign dout_valid = vsr[LATENCY-1];
    assign busy       = (word_cnt != 2'd0) | (in_flight != '0);

    // Shift accepted words into the assembly register; abort discards the partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 2'd0;
            asm_reg  <= '0;
            key_hold <= '0;
        end else if (abort) begin
            word_cnt <= 2'd0;
            asm_reg  <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 2'd1;
            asm_reg  <= {asm_reg[63:0], din};
            if (word_cnt == 2'd0) begin
                key_hold <= key_in;
            end
        end
    end

    // Present the completed block and its key to the core; the values hold until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_state <= '0;
            aes_key   <= '0;
        end else if (issue) begin
            aes_state <= {asm_reg, din};
            aes_key   <= key_hold;
        end
    end

    // Valid shift register: it follows the core pipeline, so its top bit is high with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr <= {vsr[LATENCY-2:0], issue};
        end
    end

    // Blocks whose issue flag has been raised and whose result has not yet been retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({vsr[0], dout_valid})
                2'b10:   in_flight <= in_flight + FL_W'(1);
                2'b01:   in_flight <= in_flight - FL_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Completed-block counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (dout_valid) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_128_feeder.sv
// Testbench for aes_128_feeder. It models the external core as a fixed-delay
// pipeline. A reference model works at the block level (word queue, pending
// results) and supplies the expected outputs.
module tb_aes_128_feeder;
    localparam int LATENCY = 21;
    localparam int CNT_W   = 4;   // narrow counter so that wrap-around is exercised
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [127:0]     key_in = '0;
    logic [31:0]      din = '0;
    logic             din_valid = 1'b0;
    logic             abort = 1'b0;
    logic             din_ready;
    logic [127:0]     aes_state;
    logic [127:0]     aes_key;
    logic [127:0]     core_out;
    logic [127:0]     dout;
    logic             dout_valid;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    aes_128_feeder #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .abort(abort), .aes_state(aes_state), .aes_key(aes_key),
        .core_out(core_out), .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // Core stand-in: the two known AES vectors, otherwise a keyed scramble
    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == P1 && k == K1) return C1;
        if (s == P3 && k == K3) return C3;
        return s ^ {k[95:0], k[127:96]} ^ 128'hc3c3_a5a5_0f0f_9696_3c3c_5a5a_f0f0_6969;
    endfunction

    // Core pipeline: its result lines up with the cycle N+LATENCY after the 4th accept in N
    logic [127:0] pipe [LATENCY-1];
    always @(posedge clk) begin
        pipe[0] <= core_fn(aes_state, aes_key);
        for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LATENCY-2];

    // Reference model
    typedef struct {
        int           n;     // cycle in which the 4th word was accepted
        logic [127:0] pt;
        logic [127:0] key;
    } blk_t;

    blk_t        pend[$];
    blk_t        nb;
    logic [31:0] cur_w[$];
    logic [127:0] cur_key;
    int          cyc   = 0;
    int          m_blk = 0;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            cur_w.delete();
            m_blk = 0;
        end else begin
            if (pend.size() > 0 && pend[0].n + LATENCY == cyc) begin
                void'(pend.pop_front());
                m_blk = (m_blk + 1) % (1 << CNT_W);
            end
            if (abort) begin
                cur_w.delete();
            end else if (din_valid) begin
                if (cur_w.size() == 0) cur_key = key_in;
                cur_w.push_back(din);
                if (cur_w.size() == 4) begin
                    nb.n   = cyc;
                    nb.pt  = {cur_w[0], cur_w[1], cur_w[2], cur_w[3]};
                    nb.key = cur_key;
                    pend.push_back(nb);
                    cur_w.delete();
                end
            end
        end
        cyc = cyc + 1;
    end

    function automatic bit exp_dv();
        return !rst && pend.size() > 0 && pend[0].n + LATENCY == cyc;
    endfunction

    function automatic logic [127:0] exp_dout();
        return core_fn(pend[0].pt, pend[0].key);
    endfunction

    // Blocks counted from the cycle after the issue flag until their retire cycle
    function automatic int exp_flight();
        int c = 0;
        foreach (pend[i]) if (pend[i].n + 2 <= cyc && cyc <= pend[i].n + LATENCY) c++;
        return c;
    endfunction

    function automatic bit exp_busy();
        return cur_w.size() != 0 || exp_flight() != 0;
    endfunction

    function automatic bit issue_flag_now();
        foreach (pend[i]) if (pend[i].n + 1 == cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127 - 32*i -: 32];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [127:0] k, input logic ab);
        din_valid = v;
        din       = w;
        key_in    = k;
        abort     = ab;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 128'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (aes_state !== '0) begin n_fail++; $display("FAIL reset_aes_state: got %h want 0", aes_state); end
        n_checks++; if (aes_key !== '0) begin n_fail++; $display("FAIL reset_aes_key: got %h want 0", aes_key); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (blk_cnt !== '0) begin n_fail++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_din_ready: got %b want 1", din_ready); end
        next_cycle();
    endtask

    task automatic test_single();
        int acc4 = -1;
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, word_of(P1, i), K1, 1'b0);
            if (i == 3) acc4 = cyc;
            next_cycle();
            drive(1'b0, 32'd0, K1, 1'b0);
            if (i < 3) repeat (2) next_cycle();
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (dout_valid !== (cyc == acc4 + LATENCY)) begin
                n_fail++; $display("FAIL single_dv_timing: cycle %0d got %b want %b", cyc - acc4, dout_valid, cyc == acc4 + LATENCY);
            end
            if (dout_valid === 1'b1) begin
                pulses++;
                n_checks++; if (dout !== C1) begin n_fail++; $display("FAIL single_dout: got %h want %h", dout, C1); end
            end
            if (cyc == acc4 + LATENCY + 1) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
                n_checks++; if (blk_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL single_blk_cnt: got %0d want 1", blk_cnt); end
            end
            next_cycle();
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last = -1;
        int peak = 0;
        int blk0;
        blk0 = m_blk;
        for (int c = 0; c < 32 + 30; c++) begin
            if (c < 32) drive(1'b1, word_of(P1, c % 4), K1, 1'b0);
            else drive(1'b0, 32'd0, 128'd0, 1'b0);
            @(negedge clk);
            n_checks++;
            if (dout_valid !== exp_dv()) begin n_fail++; $display("FAIL b2b_dv: cycle %0d got %b want %b", c, dout_valid, exp_dv()); end
            if (dout_valid === 1'b1) begin
                pulses++;
                n_checks++; if (dout !== C1) begin n_fail++; $display("FAIL b2b_dout: got %h want %h", dout, C1); end
                if (last >= 0) begin
                    n_checks++; if (cyc - last != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", cyc - last); end
                end
                last = cyc;
            end
            n_checks++;
            if (int'(dut.in_flight) != exp_flight()) begin
                n_fail++; $display("FAIL b2b_in_flight: cycle %0d got %0d want %0d", c, dut.in_flight, exp_flight());
            end
            if (int'(dut.in_flight) > peak) peak = int'(dut.in_flight);
            next_cycle();
        end
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
        n_checks++; if (blk_cnt !== CNT_W'(blk0 + 8)) begin n_fail++; $display("FAIL b2b_blk_cnt: got %0d want %0d", blk_cnt, CNT_W'(blk0 + 8)); end
        n_checks++; if (peak > LATENCY) begin n_fail++; $display("FAIL b2b_peak_bound: got %0d want <= %0d", peak, LATENCY); end
        $display("back_to_back: in_flight peak %0d", peak);
    endtask

    task automatic test_issue_retire();
        logic [127:0]     pt [8];
        logic [127:0]     k;
        int               pulses = 0;
        int               coin = 0;
        bit               pending_chk = 1'b0;
        int               fl_exp = 0;
        logic [CNT_W-1:0] blk_exp = '0;
        k = rand128();
        for (int i = 0; i < 8; i++) pt[i] = rand128();
        for (int c = 0; c < 32 + 30; c++) begin
            if (c < 32) drive(1'b1, word_of(pt[c/4], c % 4), k, 1'b0);
            else drive(1'b0, 32'd0, 128'd0, 1'b0);
            @(negedge clk);
            if (pending_chk) begin
                n_checks++; if (int'(dut.in_flight) != fl_exp) begin n_fail++; $display("FAIL coincide_in_flight: got %0d want %0d", dut.in_flight, fl_exp); end
                n_checks++; if (blk_cnt !== blk_exp) begin n_fail++; $display("FAIL coincide_blk_cnt: got %0d want %0d", blk_cnt, blk_exp); end
                pending_chk = 1'b0;
            end
            n_checks++;
            if (dout_valid !== exp_dv()) begin n_fail++; $display("FAIL ir_dv: cycle %0d got %b want %b", c, dout_valid, exp_dv()); end
            if (dout_valid === 1'b1 && pulses < 8) begin
                n_checks++;
                if (dout !== core_fn(pt[pulses], k)) begin n_fail++; $display("FAIL ir_dout: block %0d got %h want %h", pulses, dout, core_fn(pt[pulses], k)); end
                pulses++;
            end
            if (issue_flag_now() && exp_dv()) begin
                coin++;
                fl_exp      = exp_flight();
                blk_exp     = CNT_W'(m_blk + 1);
                pending_chk = 1'b1;
            end
            next_cycle();
        end
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL ir_pulses: got %0d want 8", pulses); end
        $display("issue_retire: %0d coincident cycles", coin);
    endtask

    task automatic test_key_latch();
        int acc4 = -1;
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, word_of(P3, i), (i < 2) ? K3 : {128{1'b1}}, 1'b0);
            if (i == 3) acc4 = cyc;
            next_cycle();
        end
        drive(1'b0, 32'd0, {128{1'b1}}, 1'b0);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            n_checks++;
            if (dout_valid !== (cyc == acc4 + LATENCY)) begin n_fail++; $display("FAIL key_dv: got %b want %b", dout_valid, cyc == acc4 + LATENCY); end
            if (dout_valid === 1'b1) begin
                pulses++;
                n_checks++; if (dout !== C3) begin n_fail++; $display("FAIL key_latch_dout: got %h want %h", dout, C3); end
            end
            next_cycle();
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL key_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_abort();
        int acc4 = -1;
        int pulses = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, K1, 1'b0);
            next_cycle();
        end
        drive(1'b1, $urandom, K1, 1'b1);
        @(negedge clk);
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL abort_din_ready: got %b want 0", din_ready); end
        next_cycle();
        drive(1'b0, 32'd0, K1, 1'b0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, word_of(P1, i), K1, 1'b0);
            if (i == 3) acc4 = cyc;
            next_cycle();
        end
        drive(1'b0, 32'd0, 128'd0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (dout_valid !== (cyc == acc4 + LATENCY)) begin n_fail++; $display("FAIL abort_dv: got %b want %b", dout_valid, cyc == acc4 + LATENCY); end
            if (dout_valid === 1'b1) begin
                pulses++;
                n_checks++; if (dout !== C1) begin n_fail++; $display("FAIL abort_dout: got %h want %h", dout, C1); end
            end
            next_cycle();
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_midflight();
        int acc4 = -1;
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, word_of(P1, i), K1, 1'b0);
            if (i == 3) acc4 = cyc;
            next_cycle();
        end
        drive(1'b0, 32'd0, 128'd0, 1'b0);
        while (cyc < acc4 + 10) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (aes_state !== '0) begin n_fail++; $display("FAIL midrst_aes_state: got %h want 0", aes_state); end
        n_checks++; if (aes_key !== '0) begin n_fail++; $display("FAIL midrst_aes_key: got %h want 0", aes_key); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (blk_cnt !== '0) begin n_fail++; $display("FAIL midrst_blk_cnt: got %0d want 0", blk_cnt); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_din_ready: got %b want 0", din_ready); end
        repeat (2) next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0) pulses++;
            next_cycle();
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d pulses want 0", pulses); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        n_checks++; if (blk_cnt !== '0) begin n_fail++; $display("FAIL midrst_blk_cnt_after: got %0d want 0", blk_cnt); end
        next_cycle();
    endtask

    task automatic test_random();
        logic v;
        logic ab;
        for (int c = 0; c < 430; c++) begin
            if (c < 400) begin
                v  = ($urandom_range(0, 9) < 7);
                ab = ($urandom_range(0, 49) == 0);
                drive(v, $urandom, rand128(), ab);
            end else begin
                drive(1'b0, 32'd0, 128'd0, 1'b0);
            end
            @(negedge clk);
            n_checks++; if (din_ready !== !abort) begin n_fail++; $display("FAIL rnd_din_ready: cycle %0d got %b want %b", c, din_ready, !abort); end
            n_checks++; if (dout_valid !== exp_dv()) begin n_fail++; $display("FAIL rnd_dv: cycle %0d got %b want %b", c, dout_valid, exp_dv()); end
            if (exp_dv()) begin
                n_checks++; if (dout !== exp_dout()) begin n_fail++; $display("FAIL rnd_dout: cycle %0d got %h want %h", c, dout, exp_dout()); end
            end
            n_checks++; if (blk_cnt !== CNT_W'(m_blk)) begin n_fail++; $display("FAIL rnd_blk_cnt: cycle %0d got %0d want %0d", c, blk_cnt, m_blk); end
            n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy: cycle %0d got %b want %b", c, busy, exp_busy()); end
            n_checks++; if (int'(dut.in_flight) != exp_flight()) begin n_fail++; $display("FAIL rnd_in_flight: cycle %0d got %0d want %0d", c, dut.in_flight, exp_flight()); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_issue_retire();
        test_key_latch();
        test_abort();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
